// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants, opcodes and fetch types for the pipeline front end.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: 2-entry FIFO of {pc, instr} words; clear wins over push and pop.
module if_fetch_buffer
    import rv32_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  logic [2*XLEN-1:0]   push_data,
    output logic [2*XLEN-1:0]   head,
    output logic [1:0]          count,
    output logic                full,
    output logic                empty
);
    logic [2*XLEN-1:0] mem_q [2];
    logic [2*XLEN-1:0] mem_d [2];
    logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = count_q == 2'd2;
    assign empty = count_q == 2'd0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = clear ? 1'b0 : push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = clear ? 1'b0 : pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = clear ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        if (push && !clear)
            mem_d[wr_ptr_q] = push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk)
        mem_q <= mem_d;

    always_ff @(posedge clk)
        if (rst_n && !clear)
            assert (!(pop && empty));
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch; issues in-order imem requests, buffers returns, feeds IF/ID.
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        EX_redirect,
    input  logic [31:0] EX_redirect_target,
    input  logic        ID_stall,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid
);
    logic [31:0] pc_q, pc_d;
    logic [1:0]  outst_q, outst_d, drop_q, drop_d;
    logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [1:0]  buf_count;
    logic        buf_full, buf_empty;
    logic [63:0] buf_head;
    logic [31:0] rsp_pc;
    logic        req_fire, rsp_live, ifid_load, bypass, buf_push, buf_pop;

    // Credits cover both in-flight requests and buffered words, so the buffer can never overflow.
    assign imem_req_valid = rst_n && !EX_redirect && ({1'b0, outst_q} + {1'b0, buf_count} < 3'd2);
    assign imem_req_addr  = pc_q;
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_live  = imem_resp_valid && drop_q == 2'd0 && !EX_redirect;
    assign ifid_load = !ifid_valid_q || !ID_stall;
    assign bypass    = rsp_live && buf_empty && ifid_load;
    assign buf_push  = rsp_live && !bypass;
    assign buf_pop   = ifid_load && !buf_empty && !EX_redirect;
    // Live requests are consecutive words ending just below pc_q; the oldest is the one returning.
    assign rsp_pc    = pc_q - {28'd0, outst_q, 2'b00};

    if_fetch_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .pop       (buf_pop),
        .clear     (EX_redirect),
        .push_data ({rsp_pc, imem_resp_data}),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        pc_d    = EX_redirect ? align_word(EX_redirect_target) : req_fire ? pc_q + 32'd4 : pc_q;
        outst_d = outst_q + {1'b0, req_fire} - {1'b0, imem_resp_valid};
        drop_d  = EX_redirect ? outst_q - {1'b0, imem_resp_valid}
                : (imem_resp_valid && drop_q != 2'd0) ? drop_q - 2'd1 : drop_q;
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (EX_redirect) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
        end else if (ifid_load) begin
            ifid_valid_d = !buf_empty || rsp_live;
            ifid_pc_d    = !buf_empty ? buf_head[63:32] : rsp_live ? rsp_pc : ifid_pc_q;
            ifid_instr_d = !buf_empty ? buf_head[31:0] : rsp_live ? imem_resp_data : NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            outst_q      <= 2'd0;
            drop_q       <= 2'd0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    always_ff @(posedge clk)
        if (rst_n && !EX_redirect)
            assert (!(buf_push && buf_full && !buf_pop) && outst_q <= 2'd2);

    assign IF_ID_valid       = ifid_valid_q;
    assign IF_ID_instruction = ifid_instr_q;
    assign IF_ID_pc          = ifid_pc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomised-memory checks of the fetch stage against hand-derived timing.
module tb_if_stage;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic        EX_redirect = 1'b0;
    logic [31:0] EX_redirect_target = 32'd0;
    logic        ID_stall = 1'b0;
    logic [31:0] IF_ID_instruction, IF_ID_pc;
    logic        IF_ID_valid;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_resp_valid    (imem_resp_valid),
        .imem_resp_data     (imem_resp_data),
        .EX_redirect        (EX_redirect),
        .EX_redirect_target (EX_redirect_target),
        .ID_stall           (ID_stall),
        .IF_ID_instruction  (IF_ID_instruction),
        .IF_ID_pc           (IF_ID_pc),
        .IF_ID_valid        (IF_ID_valid)
    );

    int tests = 0, fails = 0;
    int cyc = 0, last_due = 0, lat = 1, max_pend = 0, mem_due = 0;
    bit rnd = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // In-order memory: accepts at a cycle, answers lat cycles later, reset with the DUT.
    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_resp_valid = 1'b0;
            if (pend.size() != 0) begin
                if (pend[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end
            end
            imem_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                last_due = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                mem_due = cyc + (rnd ? int'($urandom_range(1, 3)) : lat);
                if (mem_due <= last_due) mem_due = last_due + 1;
                last_due = mem_due;
                pend.push_back('{imem_req_addr, mem_due});
                if (pend.size() > max_pend) max_pend = pend.size();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic do_reset(input int l, input bit r);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ID_stall = 1'b0;
        EX_redirect = 1'b0;
        EX_redirect_target = 32'd0;
        lat = l;
        rnd = r;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        tests++;
        if (IF_ID_valid !== 1'b0) begin fails++; $display("FAIL reset_ifid_valid: got %b want 0", IF_ID_valid); end
        tests++;
        if (IF_ID_instruction !== NOP_W) begin fails++; $display("FAIL reset_ifid_instr: got %h want %h", IF_ID_instruction, NOP_W); end
        tests++;
        if (IF_ID_pc !== 32'd0) begin fails++; $display("FAIL reset_ifid_pc: got %h want 0", IF_ID_pc); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'd0})
            begin fails++; $display("FAIL reset_first_req: got v=%b addr=%h want v=1 addr=0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] e;
        do_reset(1, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            e = 32'(4 * (c - 2));
            if (c >= 2) begin
                tests++;
                if ({IF_ID_valid, IF_ID_pc, IF_ID_instruction} !== {1'b1, e, mem_word(e)})
                    begin fails++; $display("FAIL stream c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, IF_ID_valid, IF_ID_pc, IF_ID_instruction, e, mem_word(e)); end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] e;
        do_reset(1, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            ID_stall = c >= 4 && c <= 6;
            @(negedge clk);
            e = c <= 7 ? 32'h8 : 32'(4 * (c - 5));
            if (c >= 4) begin
                tests++;
                if ({IF_ID_valid, IF_ID_pc, IF_ID_instruction} !== {1'b1, e, mem_word(e)})
                    begin fails++; $display("FAIL stall_ifid c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", c, IF_ID_valid, IF_ID_pc, IF_ID_instruction, e); end
            end
            if (c >= 4 && c <= 8) begin
                tests++;
                if (imem_req_valid !== !(c >= 5 && c <= 7))
                    begin fails++; $display("FAIL stall_req_valid c%0d: got %b want %b", c, imem_req_valid, !(c >= 5 && c <= 7)); end
            end
            if (c == 8) begin
                tests++;
                if (imem_req_addr !== 32'h14) begin fails++; $display("FAIL stall_resume_addr: got %h want 00000014", imem_req_addr); end
            end
        end
        ID_stall = 1'b0;
    endtask

    task automatic test_redirect;
        logic [31:0] e;
        do_reset(2, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            ID_stall = c == 4 || c == 5;
            EX_redirect = c == 5;
            EX_redirect_target = 32'h0000_0103;
            lat = c >= 6 ? 1 : 2;
            @(negedge clk);
            if (c == 4 || c == 5) begin
                tests++;
                if ({IF_ID_valid, IF_ID_pc} !== {1'b1, 32'h4})
                    begin fails++; $display("FAIL redir_pre c%0d: got v=%b pc=%h want v=1 pc=00000004", c, IF_ID_valid, IF_ID_pc); end
            end
            if (c == 5) begin
                tests++;
                if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_withdraw: got %b want 0", imem_req_valid); end
            end
            if (c == 6 || c == 7) begin
                tests++;
                if ({IF_ID_valid, IF_ID_instruction} !== {1'b0, NOP_W})
                    begin fails++; $display("FAIL redir_flush c%0d: got v=%b instr=%h want v=0 instr=%h", c, IF_ID_valid, IF_ID_instruction, NOP_W); end
                e = c == 6 ? 32'h100 : 32'h104;
                tests++;
                if ({imem_req_valid, imem_req_addr} !== {1'b1, e})
                    begin fails++; $display("FAIL redir_req c%0d: got v=%b addr=%h want v=1 addr=%h", c, imem_req_valid, imem_req_addr, e); end
            end
            if (c >= 8) begin
                e = 32'h100 + 32'(4 * (c - 8));
                tests++;
                if ({IF_ID_valid, IF_ID_pc, IF_ID_instruction} !== {1'b1, e, mem_word(e)})
                    begin fails++; $display("FAIL redir_target c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", c, IF_ID_valid, IF_ID_pc, IF_ID_instruction, e); end
            end
        end
        EX_redirect = 1'b0;
    endtask

    task automatic test_double_redirect;
        logic [31:0] e;
        do_reset(2, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            EX_redirect = c == 2 || c == 3;
            EX_redirect_target = c == 2 ? 32'h100 : 32'h200;
            @(negedge clk);
            if (c == 2 || c == 3) begin
                tests++;
                if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL dbl_withdraw c%0d: got %b want 0", c, imem_req_valid); end
            end
            if ((c >= 3 && c <= 6) || c == 9) begin
                tests++;
                if (IF_ID_valid !== 1'b0) begin fails++; $display("FAIL dbl_bubble c%0d: got v=%b pc=%h want v=0", c, IF_ID_valid, IF_ID_pc); end
            end
            if (c == 4 || c == 5) begin
                e = c == 4 ? 32'h200 : 32'h204;
                tests++;
                if ({imem_req_valid, imem_req_addr} !== {1'b1, e})
                    begin fails++; $display("FAIL dbl_req c%0d: got v=%b addr=%h want v=1 addr=%h", c, imem_req_valid, imem_req_addr, e); end
            end
            if (c == 7 || c == 8 || c == 10) begin
                e = c == 7 ? 32'h200 : c == 8 ? 32'h204 : 32'h208;
                tests++;
                if ({IF_ID_valid, IF_ID_pc, IF_ID_instruction} !== {1'b1, e, mem_word(e)})
                    begin fails++; $display("FAIL dbl_stream c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", c, IF_ID_valid, IF_ID_pc, IF_ID_instruction, e); end
            end
        end
        EX_redirect = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] e, prev_addr;
        logic prev_v, prev_r;
        int nvalid;
        do_reset(1, 1'b1);
        max_pend = 0;
        e = 32'd0;
        nvalid = 0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_addr = 32'd0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (IF_ID_valid === 1'b1) begin
                tests++;
                if ({IF_ID_pc, IF_ID_instruction} !== {e, mem_word(e)})
                    begin fails++; $display("FAIL rand_seq c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, IF_ID_pc, IF_ID_instruction, e, mem_word(e)); end
                e += 32'd4;
                nvalid++;
            end
            if (prev_v && !prev_r) begin
                tests++;
                if ({imem_req_valid, imem_req_addr} !== {1'b1, prev_addr})
                    begin fails++; $display("FAIL rand_req_stable c%0d: got v=%b addr=%h want v=1 addr=%h", c, imem_req_valid, imem_req_addr, prev_addr); end
            end
            prev_v = imem_req_valid;
            prev_r = imem_req_ready;
            prev_addr = imem_req_addr;
        end
        tests++;
        if (max_pend > 2) begin fails++; $display("FAIL rand_outstanding: got %0d want <=2", max_pend); end
        tests++;
        if (nvalid < 50) begin fails++; $display("FAIL rand_progress: got %0d instructions want >=50", nvalid); end
        rnd = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] e;
        do_reset(2, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            rst_n = c != 5;
            @(negedge clk);
            if (c == 4 || c == 9 || c == 10) begin
                e = c == 4 ? 32'h4 : c == 9 ? 32'h0 : 32'h4;
                tests++;
                if ({IF_ID_valid, IF_ID_pc, IF_ID_instruction} !== {1'b1, e, mem_word(e)})
                    begin fails++; $display("FAIL rstmid_stream c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", c, IF_ID_valid, IF_ID_pc, IF_ID_instruction, e); end
            end
            if (c == 5) begin
                tests++;
                if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rstmid_req_low: got %b want 0", imem_req_valid); end
            end
            if (c == 6) begin
                tests++;
                if ({IF_ID_valid, IF_ID_instruction, IF_ID_pc} !== {1'b0, NOP_W, 32'd0})
                    begin fails++; $display("FAIL rstmid_ifid: got v=%b instr=%h pc=%h want v=0 instr=%h pc=0", IF_ID_valid, IF_ID_instruction, IF_ID_pc, NOP_W); end
                tests++;
                if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'd0})
                    begin fails++; $display("FAIL rstmid_restart: got v=%b addr=%h want v=1 addr=0", imem_req_valid, imem_req_addr); end
            end
            if (c == 7 || c == 8) begin
                tests++;
                if (IF_ID_valid !== 1'b0) begin fails++; $display("FAIL rstmid_bubble c%0d: got %b want 0", c, IF_ID_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_double_redirect();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
